cache_bus1_frontend: RTL and testbench
======================================

Name: cache_bus1_frontend

Overview:
- Cache-side slave of CPU–cache bus 1 (C1/D1/A1). Sits directly downstream of the CPU model and upstream of the cache core.
- Decodes the two-cycle CPU request (tag+set, then offset) and captures write data.
- Hands one request at a time to the cache core over a valid/ready port.
- Owns the bus after CPU release: drives NOP while busy, then C1_RESPONSE plus read data.

Parameters:
ADDR1_BUS_SIZE, 15, A1 width; first-cycle tag+set field
DATA1_BUS_SIZE, 16, D1 width
CTR1_BUS_SIZE, 3, C1 width
OFFSET_BITS, 4, offset bits taken from A1 in the second address cycle

Ports:
clk  input  1  bus/system clock; all sampling on posedge
rst_n  input  1  synchronous, active-low reset
C1  inout  3  bus-1 command; CPU drives requests, frontend drives NOP/RESPONSE
D1  inout  16  bus-1 data, bidirectional
A1  input  15  bus-1 address, driven only by CPU
req_valid  output  1  request to cache core pending
req_ready  input  1  core accepts request
req_cmd  output  3  latched C1 command code (1..7)
req_tag_set  output  15  A1 latched in cycle 1
req_offset  output  OFFSET_BITS  A1[OFFSET_BITS-1:0] latched in cycle 2
req_wdata  output  32  write data, zero-extended
resp_valid  input  1  core result ready (single-cycle pulse)
resp_rdata  input  32  core read data

Behaviour:
- Reset: rst_n sampled low at posedge forces IDLE. C1=Z, D1=Z, req_valid=0, req_* regs=0.
- Reset mid-transaction abandons the request. A pending resp_valid after reset is ignored.
- Codes are in the shared package. NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7.
- RESPONSE=7, valid only while the frontend owns C1.
- IDLE:
  - C1 and D1 released to Z.
  - Sampled C1 in 1..7 latches cmd and req_tag_set=A1. For writes it also latches word0=D1; go ADDR2.
  - C1=0, Z or X means no request; stay in IDLE.
- ADDR2 (next posedge): latch req_offset=A1[OFFSET_BITS-1:0]. For WRITE32, latch word1=D1. Go ISSUE. CPU releases the bus during this cycle.
- ISSUE:
  - Drive C1=NOP, D1=Z. Assert req_valid, holding all req_* stable until req_ready is sampled high.
  - On handshake, deassert req_valid next cycle and go WAIT_RESP.
- WAIT_RESP: drive C1=NOP. On resp_valid, latch resp_rdata and go RESP1. The core never asserts resp_valid in the handshake cycle; it asserts it at least one cycle later.
- RESP1: drive C1=RESPONSE for exactly one cycle. D1 by command:
  - READ8: D1={8'h00,rdata[7:0]}.
  - READ16 and READ32: D1=rdata[15:0].
  - Write and invalidate: D1=Z.
  - Next state: RESP2 if READ32, else IDLE.
- RESP2 (READ32 only): C1=RESPONSE, D1=rdata[31:16]; next IDLE.
- Width rules for req_wdata:
  - WRITE8: {24'h0,D1[7:0]}.
  - WRITE16: {16'h0,D1}.
  - WRITE32: {word1,word0}.
  - Reads and invalidate: 0.
- Bus is released on the posedge leaving RESP1/RESP2. A new command is accepted no earlier than the first IDLE cycle, so there is no back-to-back overlap.
- Min latency from first address cycle to C1=RESPONSE = 4 cycles (req_ready and resp_valid both 1-cycle).

Decomposition:
- Package cache_bus_pkg:
  - C1_* command codes and widths.
  - State enum {IDLE, ADDR2, ISSUE, WAIT_RESP, RESP1, RESP2}.
  - Helper function cmd_is_write(cmd).
- One sub-module bus1_tristate_driver. It turns internal drive-enable/value pairs into C1/D1 inout assignments, and exposes sampled C1_in/D1_in.
- FSM, capture registers and response muxing stay in the top.

Test Plan:
- READ8 to A1=15'h0003 then offset 4'h2; core rdata=32'hDEADBEEF → req_tag_set=3, req_offset=2. C1=NOP while waiting, then one cycle C1=7, D1=16'h00EF; then Z.
- READ32; rdata=32'h12345678 → two RESPONSE cycles: D1=16'h5678, then 16'h1234. Back to IDLE with C1=Z.
- WRITE32 with D1=16'hBEEF then 16'hCAFE → req_wdata=32'hCAFEBEEF, req_cmd=7. One RESPONSE cycle with D1=Z.
- req_ready held low 5 cycles → req_valid and req_* stable all 5 cycles, C1=NOP throughout. Handshake on cycle 6.
- rst_n low during WAIT_RESP, then resp_valid pulse → no RESPONSE driven, C1=Z, FSM in IDLE, req_valid=0.
- C1=Z or NOP for 10 cycles in IDLE → no req_valid, bus never driven.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the CPU-cache bus 1 frontend: command codes,
// frontend FSM states and command classification helpers.
package cache_bus_pkg;

    // Width of the core-side request/response data words.
    localparam int WORD_W = 32;

    // C1 command codes driven by the CPU.
    localparam logic [2:0] C1_NOP             = 3'd0;
    localparam logic [2:0] C1_READ8           = 3'd1;
    localparam logic [2:0] C1_READ16          = 3'd2;
    localparam logic [2:0] C1_READ32          = 3'd3;
    localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8          = 3'd5;
    localparam logic [2:0] C1_WRITE16         = 3'd6;
    localparam logic [2:0] C1_WRITE32         = 3'd7;

    // Code driven by the frontend while it owns C1; shares the value of
    // WRITE32 but is only meaningful in the frontend-to-CPU direction.
    localparam logic [2:0] C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR2,
        ISSUE,
        WAIT_RESP,
        RESP1,
        RESP2
    } state_e;

    // True for the three commands that carry write data on D1.
    function automatic logic cmd_is_write(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

endpackage

// File: rtl/bus1_tristate_driver.sv
// Tristate pad logic for bus 1: turns enable/value pairs into the shared
// C1/D1 nets and returns whatever is currently on those nets.
module bus1_tristate_driver #(
    parameter int CTR_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic              c1_oe_i,
    input  logic [CTR_W-1:0]  c1_val_i,
    input  logic              d1_oe_i,
    input  logic [DATA_W-1:0] d1_val_i,
    inout  wire  [CTR_W-1:0]  C1,
    inout  wire  [DATA_W-1:0] D1,
    output logic [CTR_W-1:0]  c1_in_o,
    output logic [DATA_W-1:0] d1_in_o
);

    assign C1 = c1_oe_i ? c1_val_i : {CTR_W{1'bz}};
    assign D1 = d1_oe_i ? d1_val_i : {DATA_W{1'bz}};

    assign c1_in_o = C1;
    assign d1_in_o = D1;

endmodule

// File: rtl/cache_bus1_frontend.sv
// Cache-side slave of CPU-cache bus 1. Decodes the two-cycle CPU request,
// hands it to the cache core over valid/ready, then owns the bus to return
// NOP while busy followed by RESPONSE beats carrying read data.
module cache_bus1_frontend
    import cache_bus_pkg::*;
#(
    parameter int ADDR1_BUS_SIZE = 15,
    parameter int DATA1_BUS_SIZE = 16,
    parameter int CTR1_BUS_SIZE  = 3,
    parameter int OFFSET_BITS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    inout  wire  [CTR1_BUS_SIZE-1:0]  C1,
    inout  wire  [DATA1_BUS_SIZE-1:0] D1,
    input  logic [ADDR1_BUS_SIZE-1:0] A1,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [CTR1_BUS_SIZE-1:0]  req_cmd,
    output logic [ADDR1_BUS_SIZE-1:0] req_tag_set,
    output logic [OFFSET_BITS-1:0]    req_offset,
    output logic [WORD_W-1:0]         req_wdata,
    input  logic                      resp_valid,
    input  logic [WORD_W-1:0]         resp_rdata
);

    state_e                    state_q, state_d;
    logic [CTR1_BUS_SIZE-1:0]  cmd_q, cmd_d;
    logic [ADDR1_BUS_SIZE-1:0] tag_set_q, tag_set_d;
    logic [OFFSET_BITS-1:0]    offset_q, offset_d;
    logic [DATA1_BUS_SIZE-1:0] word0_q, word0_d;
    logic [DATA1_BUS_SIZE-1:0] word1_q, word1_d;
    logic [WORD_W-1:0]         rdata_q, rdata_d;

    logic                      c1_oe;
    logic [CTR1_BUS_SIZE-1:0]  c1_val;
    logic                      d1_oe;
    logic [DATA1_BUS_SIZE-1:0] d1_val;
    logic [CTR1_BUS_SIZE-1:0]  c1_in;
    logic [DATA1_BUS_SIZE-1:0] d1_in;

    bus1_tristate_driver #(
        .CTR_W  (CTR1_BUS_SIZE),
        .DATA_W (DATA1_BUS_SIZE)
    ) u_drv (
        .c1_oe_i  (c1_oe),
        .c1_val_i (c1_val),
        .d1_oe_i  (d1_oe),
        .d1_val_i (d1_val),
        .C1       (C1),
        .D1       (D1),
        .c1_in_o  (c1_in),
        .d1_in_o  (d1_in)
    );

    // Next-state, capture and bus-drive decisions for the request lifecycle.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tag_set_d = tag_set_q;
        offset_d  = offset_q;
        word0_d   = word0_q;
        word1_d   = word1_q;
        rdata_d   = rdata_q;
        c1_oe     = 1'b0;
        c1_val    = CTR1_BUS_SIZE'(C1_NOP);
        d1_oe     = 1'b0;
        d1_val    = '0;

        case (state_q)
            IDLE: begin
                // An undriven or unknown C1 never compares unequal to NOP
                // as true, so it is treated as no request.
                if (c1_in != CTR1_BUS_SIZE'(C1_NOP)) begin
                    cmd_d     = c1_in;
                    tag_set_d = A1;
                    if (cmd_is_write(c1_in)) begin
                        word0_d = d1_in;
                    end
                    state_d = ADDR2;
                end
            end
            ADDR2: begin
                offset_d = A1[OFFSET_BITS-1:0];
                if (cmd_q == CTR1_BUS_SIZE'(C1_WRITE32)) begin
                    word1_d = d1_in;
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                c1_oe = 1'b1;
                if (req_ready) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                c1_oe = 1'b1;
                if (resp_valid) begin
                    rdata_d = resp_rdata;
                    state_d = RESP1;
                end
            end
            RESP1: begin
                c1_oe  = 1'b1;
                c1_val = CTR1_BUS_SIZE'(C1_RESPONSE);
                case (cmd_q)
                    CTR1_BUS_SIZE'(C1_READ8): begin
                        d1_oe  = 1'b1;
                        d1_val = DATA1_BUS_SIZE'(rdata_q[7:0]);
                    end
                    CTR1_BUS_SIZE'(C1_READ16),
                    CTR1_BUS_SIZE'(C1_READ32): begin
                        d1_oe  = 1'b1;
                        d1_val = rdata_q[DATA1_BUS_SIZE-1:0];
                    end
                    default: ;
                endcase
                state_d = (cmd_q == CTR1_BUS_SIZE'(C1_READ32)) ? RESP2 : IDLE;
            end
            RESP2: begin
                c1_oe   = 1'b1;
                c1_val  = CTR1_BUS_SIZE'(C1_RESPONSE);
                d1_oe   = 1'b1;
                d1_val  = rdata_q[WORD_W-1:DATA1_BUS_SIZE];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            tag_set_q <= '0;
            offset_q  <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tag_set_q <= tag_set_d;
            offset_q  <= offset_d;
            word0_q   <= word0_d;
            word1_q   <= word1_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write data zero-extended to the core word according to access size.
    always_comb begin
        req_wdata = '0;
        case (cmd_q)
            CTR1_BUS_SIZE'(C1_WRITE8):  req_wdata = WORD_W'(word0_q[7:0]);
            CTR1_BUS_SIZE'(C1_WRITE16): req_wdata = WORD_W'(word0_q);
            CTR1_BUS_SIZE'(C1_WRITE32): req_wdata = WORD_W'({word1_q, word0_q});
            default: ;
        endcase
    end

    assign req_valid   = (state_q == ISSUE);
    assign req_cmd     = cmd_q;
    assign req_tag_set = tag_set_q;
    assign req_offset  = offset_q;

endmodule

// File: tb/tb_cache_bus1_frontend.sv
// Self-checking bench for cache_bus1_frontend: directed vector table,
// hand-written reset/idle sequences and randomized transactions checked
// against a transaction-level reference model.
module tb_cache_bus1_frontend;
    import cache_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [14:0] A1;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [14:0] req_tag_set;
    logic [3:0]  req_offset;
    logic [31:0] req_wdata;

    // CPU-side drivers of the shared bus.
    logic        cpu_c1_oe;
    logic [2:0]  cpu_c1;
    logic        cpu_d1_oe;
    logic [15:0] cpu_d1;
    wire  [2:0]  C1;
    wire  [15:0] D1;
    assign C1 = cpu_c1_oe ? cpu_c1 : 3'bzzz;
    assign D1 = cpu_d1_oe ? cpu_d1 : 16'hzzzz;

    cache_bus1_frontend dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .C1          (C1),
        .D1          (D1),
        .A1          (A1),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_tag_set (req_tag_set),
        .req_offset  (req_offset),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata)
    );

    // Whether the frontend is actively driving each bus (Z otherwise).
    wire dut_c1_oe = dut.u_drv.c1_oe_i;
    wire dut_d1_oe = dut.u_drv.d1_oe_i;

    typedef struct {
        logic [2:0]  cmd;
        logic [14:0] tag;
        logic [3:0]  off;
        logic [15:0] w0;
        logic [15:0] w1;
        int          rdy_dly;
        int          resp_dly;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        int          exp_beats;
        logic        exp_drv;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] cmd, input logic [14:0] tag, input logic [3:0] off,
                                input logic [15:0] w0, input logic [15:0] w1, input int rdy, input int rsp,
                                input logic [31:0] rdata, input logic [31:0] ewd, input int beats,
                                input logic drv, input logic [15:0] d0, input logic [15:0] d1);
        vec_t v;
        v.cmd = cmd; v.tag = tag; v.off = off; v.w0 = w0; v.w1 = w1;
        v.rdy_dly = rdy; v.resp_dly = rsp; v.rdata = rdata;
        v.exp_wdata = ewd; v.exp_beats = beats; v.exp_drv = drv; v.exp_d0 = d0; v.exp_d1 = d1;
        return v;
    endfunction

    // Reference model: derive the expected core request and bus response
    // purely from the command semantics.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_wdata = 32'd0;
        r.exp_beats = 1;
        r.exp_drv   = 1'b0;
        r.exp_d0    = 16'd0;
        r.exp_d1    = 16'd0;
        case (v.cmd)
            C1_READ8:   begin r.exp_drv = 1'b1; r.exp_d0 = 16'(v.rdata % 256); end
            C1_READ16:  begin r.exp_drv = 1'b1; r.exp_d0 = 16'(v.rdata % 65536); end
            C1_READ32:  begin
                r.exp_drv = 1'b1; r.exp_beats = 2;
                r.exp_d0 = 16'(v.rdata % 65536);
                r.exp_d1 = 16'(v.rdata / 65536);
            end
            C1_WRITE8:  r.exp_wdata = 32'(v.w0 % 256);
            C1_WRITE16: r.exp_wdata = 32'(v.w0);
            C1_WRITE32: r.exp_wdata = 32'(v.w1) * 65536 + 32'(v.w0);
            default: ;
        endcase
        return r;
    endfunction

    // CPU side of the two address cycles; leaves the DUT in its issue phase.
    task automatic addr_phase(input vec_t v, input string nm);
        cpu_c1_oe = 1'b1;
        cpu_c1    = v.cmd;
        A1        = v.tag;
        cpu_d1_oe = (v.cmd >= C1_WRITE8);
        cpu_d1    = v.w0;
        step();
        check({nm, ".addr2_valid"}, 32'(req_valid), 32'd0);
        check({nm, ".addr2_c1_released"}, 32'(dut_c1_oe), 32'd0);
        cpu_c1_oe = 1'b0;
        A1        = {~v.tag[14:4], v.off};
        cpu_d1    = v.w1;
        step();
        cpu_d1_oe = 1'b0;
        A1        = 15'($urandom);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        addr_phase(v, nm);
        for (int i = 0; i <= v.rdy_dly; i++) begin
            check({nm, ".issue_valid"}, 32'(req_valid), 32'd1);
            check({nm, ".issue_cmd"}, 32'(req_cmd), 32'(v.cmd));
            check({nm, ".issue_tag"}, 32'(req_tag_set), 32'(v.tag));
            check({nm, ".issue_off"}, 32'(req_offset), 32'(v.off));
            check({nm, ".issue_wdata"}, req_wdata, v.exp_wdata);
            check({nm, ".issue_c1_drv"}, 32'(dut_c1_oe), 32'd1);
            check({nm, ".issue_c1_nop"}, 32'(C1), 32'(C1_NOP));
            check({nm, ".issue_d1_rel"}, 32'(dut_d1_oe), 32'd0);
            req_ready = (i == v.rdy_dly);
            step();
        end
        req_ready = 1'b0;
        for (int i = 0; i <= v.resp_dly; i++) begin
            check({nm, ".wait_valid"}, 32'(req_valid), 32'd0);
            check({nm, ".wait_c1_drv"}, 32'(dut_c1_oe), 32'd1);
            check({nm, ".wait_c1_nop"}, 32'(C1), 32'(C1_NOP));
            check({nm, ".wait_d1_rel"}, 32'(dut_d1_oe), 32'd0);
            if (i == v.resp_dly) begin
                resp_valid = 1'b1;
                resp_rdata = v.rdata;
            end else begin
                resp_rdata = $urandom;
            end
            step();
        end
        resp_valid = 1'b0;
        resp_rdata = $urandom;
        for (int k = 0; k < v.exp_beats; k++) begin
            check({nm, ".resp_c1_drv"}, 32'(dut_c1_oe), 32'd1);
            check({nm, ".resp_c1_code"}, 32'(C1), 32'(C1_RESPONSE));
            check({nm, ".resp_d1_drv"}, 32'(dut_d1_oe), 32'(v.exp_drv));
            if (v.exp_drv) check({nm, ".resp_d1_data"}, 32'(D1), 32'((k == 0) ? v.exp_d0 : v.exp_d1));
            step();
        end
        check({nm, ".end_c1_rel"}, 32'(dut_c1_oe), 32'd0);
        check({nm, ".end_d1_rel"}, 32'(dut_d1_oe), 32'd0);
        check({nm, ".end_valid"}, 32'(req_valid), 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;

        tbl[0] = mk(C1_READ8,           15'h0003, 4'h2, 16'h0000, 16'h0000, 0, 0, 32'hDEADBEEF,
                    32'h00000000, 1, 1'b1, 16'h00EF, 16'h0000);
        tbl[1] = mk(C1_READ32,          15'h1A2B, 4'hF, 16'h0000, 16'h0000, 1, 2, 32'h12345678,
                    32'h00000000, 2, 1'b1, 16'h5678, 16'h1234);
        tbl[2] = mk(C1_WRITE32,         15'h7FFF, 4'h0, 16'hBEEF, 16'hCAFE, 0, 1, 32'hFFFFFFFF,
                    32'hCAFEBEEF, 1, 1'b0, 16'h0000, 16'h0000);
        tbl[3] = mk(C1_READ16,          15'h4000, 4'h7, 16'h0000, 16'h0000, 5, 0, 32'hA5A55A5A,
                    32'h00000000, 1, 1'b1, 16'h5A5A, 16'h0000);
        tbl[4] = mk(C1_WRITE8,          15'h0155, 4'h9, 16'h1234, 16'h5678, 2, 0, 32'h00000000,
                    32'h00000034, 1, 1'b0, 16'h0000, 16'h0000);
        tbl[5] = mk(C1_WRITE16,         15'h2AAA, 4'hC, 16'hABCD, 16'h9999, 0, 3, 32'h11112222,
                    32'h0000ABCD, 1, 1'b0, 16'h0000, 16'h0000);
        tbl[6] = mk(C1_INVALIDATE_LINE, 15'h0F0F, 4'h5, 16'hFFFF, 16'hFFFF, 1, 1, 32'h87654321,
                    32'h00000000, 1, 1'b0, 16'h0000, 16'h0000);

        rst_n      = 1'b0;
        A1         = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        cpu_c1_oe  = 1'b0;
        cpu_c1     = '0;
        cpu_d1_oe  = 1'b0;
        cpu_d1     = '0;
        step();
        step();

        // Reset state
        check("rst.valid", 32'(req_valid), 32'd0);
        check("rst.cmd", 32'(req_cmd), 32'd0);
        check("rst.tag", 32'(req_tag_set), 32'd0);
        check("rst.off", 32'(req_offset), 32'd0);
        check("rst.wdata", req_wdata, 32'd0);
        check("rst.c1_rel", 32'(dut_c1_oe), 32'd0);
        check("rst.d1_rel", 32'(dut_d1_oe), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Idle bus with C1 alternately released and driven NOP
        for (int i = 0; i < 10; i++) begin
            cpu_c1_oe = (i % 2 == 1);
            cpu_c1    = C1_NOP;
            A1        = 15'($urandom);
            step();
            check("idle.valid", 32'(req_valid), 32'd0);
            check("idle.c1_rel", 32'(dut_c1_oe), 32'd0);
            check("idle.d1_rel", 32'(dut_d1_oe), 32'd0);
        end
        cpu_c1_oe = 1'b0;

        // Reset while waiting for the core, then a stale resp_valid pulse
        v = model(mk(C1_READ16, 15'h0321, 4'h4, 16'h0, 16'h0, 0, 0, 32'h0BADF00D, 0, 0, 1'b0, 0, 0));
        addr_phase(v, "rstmid");
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("rstmid.wait_c1_drv", 32'(dut_c1_oe), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        resp_rdata = 32'h0BADF00D;
        check("rstmid.c1_rel", 32'(dut_c1_oe), 32'd0);
        check("rstmid.valid", 32'(req_valid), 32'd0);
        check("rstmid.cmd", 32'(req_cmd), 32'd0);
        check("rstmid.tag", 32'(req_tag_set), 32'd0);
        step();
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid.after_c1_rel", 32'(dut_c1_oe), 32'd0);
            check("rstmid.after_d1_rel", 32'(dut_d1_oe), 32'd0);
            check("rstmid.after_valid", 32'(req_valid), 32'd0);
            step();
        end
        run_txn(tbl[0], "post_rst");

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            v.cmd      = 3'($urandom_range(1, 7));
            v.tag      = 15'($urandom);
            v.off      = 4'($urandom);
            v.w0       = 16'($urandom);
            v.w1       = 16'($urandom);
            v.rdy_dly  = $urandom_range(0, 3);
            v.resp_dly = $urandom_range(0, 3);
            v.rdata    = $urandom;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", n));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
